// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single Common Data Bus.
// Grants one completing functional unit per cycle (combinational grant),
// then broadcasts the winner's destination tag from a register on the
// following cycle. A NULL (all-ones) tag is granted and drained but does
// not raise the broadcast-valid.
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 7,
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            flush,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            CAM_en,
   output logic [TAG_W-1:0]                CDB_out,
   output logic [PTR_W-1:0]                rr_ptr
);

   localparam logic [TAG_W-1:0] NULL_TAG = {TAG_W{1'b1}};

   // Registered state
   logic                cam_en_q, cam_en_d;
   logic [TAG_W-1:0]    cdb_q, cdb_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;

   // Arbitration results
   logic                found_s;
   logic [PTR_W-1:0]    win_s;
   logic [PTR_W-1:0]    idx_s;
   logic                win_ok_s;
   logic                gnt_ok_s;
   logic [TAG_W-1:0]    win_tag_s;
   logic [NUM_REQ-1:0]  grant_s;

   // Arbitration is live only when enabled and not squashed; reset also
   // forces the visible grant low so no FU thinks it drained during reset.
   assign win_ok_s = enable & ~flush & found_s;
   assign gnt_ok_s = win_ok_s & ~reset;

   // Scan from the round-robin pointer upward (wrapping naturally, since
   // NUM_REQ is a power of two) and pick the first valid requester.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s = ptr_q + i[PTR_W-1:0];
         if (!found_s && req_valid[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Decode the winner index into a one-hot grant vector.
   always_comb begin
      grant_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_ok_s && (win_s == k[PTR_W-1:0])) begin
            grant_s[k] = 1'b1;
         end else begin
            grant_s[k] = 1'b0;
         end
      end
   end

   assign win_tag_s = req_tag[win_s];

   // Next-state for the broadcast register and the priority pointer.
   always_comb begin
      cam_en_d = 1'b0;
      cdb_d    = NULL_TAG;
      ptr_d    = ptr_q;
      if (win_ok_s) begin
         cdb_d    = win_tag_s;
         cam_en_d = (win_tag_s != NULL_TAG);
         ptr_d    = win_s + {{(PTR_W-1){1'b0}}, 1'b1};
      end else if (flush) begin
         ptr_d    = '0;
      end else begin
         ptr_d    = ptr_q;
      end
   end

   // State registers; reset clears the broadcast immediately, even mid-cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cam_en_q <= 1'b0;
         cdb_q    <= NULL_TAG;
         ptr_q    <= '0;
      end else begin
         cam_en_q <= cam_en_d;
         cdb_q    <= cdb_d;
         ptr_q    <= ptr_d;
      end
   end

   assign grant   = grant_s;
   assign CAM_en  = cam_en_q;
   assign CDB_out = cdb_q;
   assign rr_ptr  = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin model (modulo-arithmetic scan, plain integers).
module tb_cdb_arbiter;

   localparam int N = 4;
   localparam logic [6:0] NULL_T = 7'h7F;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic             flush;
   logic [3:0]       req_valid;
   logic [3:0][6:0]  req_tag;
   logic [3:0]       grant;
   logic             CAM_en;
   logic [6:0]       CDB_out;
   logic [1:0]       rr_ptr;

   cdb_arbiter #(.NUM_REQ(4), .TAG_W(7)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .flush     (flush),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .grant     (grant),
      .CAM_en    (CAM_en),
      .CDB_out   (CDB_out),
      .rr_ptr    (rr_ptr)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // model state
   int         m_ptr = 0;
   logic       m_cam = 1'b0;
   logic [6:0] m_cdb = 7'h7F;
   int         last_w;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model_winner(input int ptr, input logic [3:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   task automatic run_cycle(input logic en, input logic fl, input logic [3:0] v,
                            input logic [3:0][6:0] t);
      int w;
      logic [3:0] exp_g;
      @(negedge clock);
      enable = en; flush = fl; req_valid = v; req_tag = t;
      #1;
      w = (en && !fl) ? model_winner(m_ptr, v) : -1;
      exp_g = (w >= 0) ? 4'(1 << w) : 4'b0000;
      chk("grant", {28'd0, grant}, {28'd0, exp_g});
      @(posedge clock);
      if (w >= 0) begin
         m_cdb = t[w];
         m_cam = (t[w] != NULL_T);
         m_ptr = (w + 1) % N;
      end else begin
         m_cam = 1'b0;
         m_cdb = NULL_T;
         if (fl) m_ptr = 0;
      end
      #1;
      chk("cam_en",  {31'd0, CAM_en},  {31'd0, m_cam});
      chk("cdb_out", {25'd0, CDB_out}, {25'd0, m_cdb});
      chk("rr_ptr",  {30'd0, rr_ptr},  32'(m_ptr));
      last_w = w;
   endtask

   logic [3:0][6:0] tg;
   logic [3:0]      pv;
   logic [3:0][6:0] pt;
   int              waitc [4];
   logic            en_r, fl_r;

   initial begin
      reset = 1'b1; enable = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0;
      #1;
      chk("rst_cam",   {31'd0, CAM_en},  32'd0);
      chk("rst_cdb",   {25'd0, CDB_out}, 32'h7F);
      chk("rst_ptr",   {30'd0, rr_ptr},  32'd0);
      chk("rst_grant", {28'd0, grant},   32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // single request
      tg = '0; tg[2] = 7'd5;
      run_cycle(1'b1, 1'b0, 4'b0100, tg);
      chk("single_cam", {31'd0, CAM_en},  32'd1);
      chk("single_cdb", {25'd0, CDB_out}, 32'd5);
      chk("single_ptr", {30'd0, rr_ptr},  32'd3);

      // flush with no requests brings pointer back to 0
      run_cycle(1'b1, 1'b1, 4'b0000, tg);

      // round-robin fairness, all four requesting
      tg[0] = 7'd10; tg[1] = 7'd11; tg[2] = 7'd12; tg[3] = 7'd13;
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 1'b0, 4'b1111, tg);
         chk("rr_cdb", {25'd0, CDB_out}, 32'(10 + i));
      end
      chk("rr_wrap", {30'd0, rr_ptr}, 32'd0);

      // NULL tag is granted but does not broadcast
      tg[0] = NULL_T;
      run_cycle(1'b1, 1'b0, 4'b0001, tg);
      chk("null_cam", {31'd0, CAM_en}, 32'd0);
      chk("null_ptr", {30'd0, rr_ptr}, 32'd1);

      // move pointer to 2, then flush collides with requests
      tg[1] = 7'd20;
      run_cycle(1'b1, 1'b0, 4'b0010, tg);
      chk("pre_flush_ptr", {30'd0, rr_ptr}, 32'd2);
      tg[2] = 7'd30; tg[3] = 7'd31;
      run_cycle(1'b1, 1'b1, 4'b1100, tg);
      chk("flush_ptr", {30'd0, rr_ptr}, 32'd0);

      // enable gating
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 4'b0010, tg);
      @(negedge clock);
      enable = 1'b1;
      #1;
      chk("enable_grant", {28'd0, grant}, 32'h2);
      run_cycle(1'b1, 1'b0, 4'b0010, tg);

      // asynchronous reset in the middle of a broadcast
      tg[0] = 7'd3;
      run_cycle(1'b1, 1'b0, 4'b0001, tg);
      chk("pre_rst_cam", {31'd0, CAM_en},  32'd1);
      chk("pre_rst_cdb", {25'd0, CDB_out}, 32'd3);
      req_valid = 4'b1111;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_cam",   {31'd0, CAM_en},  32'd0);
      chk("arst_cdb",   {25'd0, CDB_out}, 32'h7F);
      chk("arst_ptr",   {30'd0, rr_ptr},  32'd0);
      chk("arst_grant", {28'd0, grant},   32'd0);
      m_ptr = 0; m_cam = 1'b0; m_cdb = NULL_T;
      @(negedge clock);
      reset = 1'b0;

      // randomized traffic honouring the requester handshake
      pv = '0; pt = '0;
      for (int k = 0; k < 4; k++) waitc[k] = 0;
      for (int c = 0; c < 500; c++) begin
         en_r = ($urandom_range(0, 9) != 0);
         fl_r = ($urandom_range(0, 24) == 0);
         for (int k = 0; k < 4; k++) begin
            if (!pv[k] && ($urandom_range(0, 2) == 0)) begin
               pv[k] = 1'b1;
               pt[k] = ($urandom_range(0, 7) == 0) ? NULL_T : 7'($urandom_range(0, 126));
            end
         end
         run_cycle(en_r, fl_r, pv, pt);
         for (int k = 0; k < 4; k++) begin
            if (pv[k] && en_r && !fl_r) waitc[k]++;
         end
         if (fl_r) begin
            pv = '0;
            for (int k = 0; k < 4; k++) waitc[k] = 0;
         end else if (last_w >= 0) begin
            chk("fairness", {31'd0, (waitc[last_w] <= N)}, 32'd1);
            waitc[last_w] = 0;
            pv[last_w] = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the single Common Data Bus. Functional units (ALU, MULT, LD, BR) that finish a result request the bus. Exactly one requester is granted per cycle. The winner's destination tag is broadcast from a register to the RS CAM ports (`CAM_en`, `CDB_in`) and to the map table one cycle later. The arbiter sits between the FU completion stage and the RS/ROB wakeup logic.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting FUs; must be a power of two (2..8).
- `TAG_W`, default 7: physical register tag width (`PHYS_REG`).

Ports:
- `clock`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high reset.
- `enable`: input, 1 bit. Arbitration enable.
- `flush`: input, 1 bit. Squash on branch mispredict.
- `req_valid`: input, `NUM_REQ` bits. Per-FU result-ready request.
- `req_tag`: input, `NUM_REQ` x `TAG_W`. Per-FU destination tag.
- `grant`: output, `NUM_REQ` bits. Combinational one-hot (or zero) grant, valid in the same cycle as the request.
- `CAM_en`: output, 1 bit. Registered broadcast-valid to the RS/map table.
- `CDB_out`: output, `TAG_W` bits. Registered broadcast tag; feeds the RS input `CDB_in`.
- `rr_ptr`: output, log2(`NUM_REQ`) bits. Current highest-priority index, for debug and verification.

## Operation
- NULL tag is all-ones (`{TAG_W{1'b1}}`). It marks a result with no destination register, e.g. a store or a branch without link.
- Arbitration is combinational when `enable`=1 and `flush`=0:
  - Scan indices `rr_ptr`, `rr_ptr+1`, …, wrapping mod `NUM_REQ`.
  - The first index with `req_valid` set is the winner `w`; `grant[w]`=1 and all other grant bits are 0.
  - If no `req_valid` bit is set, `grant` is all zero.
- When `enable`=0 or `flush`=1, `grant` is all zero regardless of the requests.
- Register update at posedge when a winner exists:
  - `CDB_out` <= `req_tag[w]`.
  - `CAM_en` <= 1, unless `req_tag[w]` is NULL, in which case `CAM_en` <= 0. A NULL-tag requester is still granted and drained.
  - `rr_ptr` <= (w+1) mod `NUM_REQ`.
- Register update at posedge when there is no winner, `enable`=0, or `flush`=0 is false:
  - `CAM_en` <= 0 and `CDB_out` <= NULL.
  - `rr_ptr` holds, except on `flush`=1, where `rr_ptr` <= 0.
- Requester handshake:
  - A requester keeps `req_valid` and `req_tag` stable until it samples `grant`=1 at a rising edge.
  - In the cycle after a grant, the requester either drops `req_valid` or presents a new tag.
  - `req_valid` is never withdrawn before it is granted, except on `flush`.
  - The arbiter does not buffer requests. An ungranted FU must stall its own pipeline (`stall = req_valid & ~grant`).
- Fairness: a continuously asserted request is granted within `NUM_REQ` cycles of enabled, unflushed operation.
- Reset, asynchronous, takes effect immediately even mid-broadcast:
  - `CAM_en`=0, `CDB_out`=NULL, `rr_ptr`=0.
  - `grant` becomes 0 once `reset` is high (reset gates `grant`).

## Timing
- Request to grant: 0 cycles (combinational in the same cycle).
- Grant to `CAM_en`/`CDB_out` visible: 1 cycle (registered). The RS wakes dependents on the edge after the broadcast cycle.
- Maximum throughput is one broadcast per cycle. Back-to-back grants to different or the same requesters are allowed.
- Same-cycle `flush` and requests: `flush` wins. No grant, the next cycle's `CAM_en`=0, and `rr_ptr`=0.
- `enable` deasserted mid-stream: broadcasts stop on the next edge, and `rr_ptr` is preserved for resumption.
- Wrap-around: a winner at index `NUM_REQ-1` sets `rr_ptr` to 0.
- `reset` release: the first grant is possible in the first cycle with `enable`=1. The pointer starts at 0, so index 0 has the highest priority.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle while `CAM_en`=1 and `CDB_out`=7'd3. Required: immediately `CAM_en`=0, `CDB_out`=7'h7F, `rr_ptr`=0, `grant`=0.
- Single request: `enable`=1, `req_valid`=4'b0100, `req_tag[2]`=7'd5. Required: `grant`=4'b0100 in the same cycle; after the edge `CAM_en`=1, `CDB_out`=7'd5, `rr_ptr`=3.
- Round-robin fairness: `req_valid`=4'b1111 held with tags 7'd10..7'd13 and `rr_ptr`=0. Required: over 4 cycles, grants 0001, 0010, 0100, 1000; `CDB_out` sequence 10, 11, 12, 13; `rr_ptr` wraps to 0.
- NULL tag: `req_valid`=4'b0001, `req_tag[0]`=7'h7F. Required: `grant`=4'b0001; next cycle `CAM_en`=0, `CDB_out`=7'h7F, `rr_ptr`=1.
- Flush collision: `rr_ptr`=2, `req_valid`=4'b1100, `flush`=1. Required: `grant`=0; next cycle `CAM_en`=0 and `rr_ptr`=0.
- Enable gating: `enable`=0 with `req_valid`=4'b0010 for 3 cycles. Required: `grant`=0 and `CAM_en`=0 throughout, `rr_ptr` unchanged. Then `enable`=1: `grant`=4'b0010 in the same cycle.
